// File: rtl/decoder_pkg.sv
// Shared types and constants for the decoder stimulus sequencer and its button debouncer.
package decoder_pkg;

  localparam int unsigned SEQ_WIDTH = 3;
  localparam logic [SEQ_WIDTH-1:0] SEQ_MAX = 3'd7;

  typedef enum logic [1:0] {
    StIdle,
    StConfirm,
    StPressed
  } deb_state_e;

  // Next sequence value, wrapping at both ends of 0..SEQ_MAX.
  function automatic logic [SEQ_WIDTH-1:0] seq_next(input logic [SEQ_WIDTH-1:0] cur,
                                                     input logic up);
    logic [SEQ_WIDTH-1:0] nxt;
    if (up) begin
      nxt = (cur == SEQ_MAX) ? '0 : cur + SEQ_WIDTH'(1);
    end else begin
      nxt = (cur == '0) ? SEQ_MAX : cur - SEQ_WIDTH'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-flop synchronizer, three-state confirm FSM and a one-cycle
// pulse on acceptance. A button already held when reset is released is ignored until it
// has been seen released once.
module button_debouncer
  import decoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic step_pulse
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [1:0]    fill_q;
  logic          armed_q;
  logic          btn_sync;
  deb_state_e    state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  assign btn_sync = sync_q[1];

  // Synchronizer plus arming: fill_q marks when sync_q holds real samples, armed_q is set
  // once a released button has been observed after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      fill_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
      fill_q <= {fill_q[0], 1'b1};
      if (fill_q[1] && !btn_sync) begin
        armed_q <= 1'b1;
      end
    end
  end

  // FSM state and sample counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: count consecutive high samples to accept, consecutive low samples to release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (armed_q && btn_sync) begin
          state_d = StConfirm;
          cnt_d   = CntW'(1);
        end
      end
      StConfirm: begin
        if (!btn_sync) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q >= LastCnt) begin
          state_d = StPressed;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StPressed: begin
        if (btn_sync) begin
          cnt_d = '0;
        end else if (cnt_q >= LastCnt) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Pulse only on the CONFIRM->PRESSED transition.
  always_comb begin
    step_pulse = (state_q == StConfirm) && btn_sync && (cnt_q >= LastCnt);
  end

endmodule

// File: rtl/decoder_stim_sequencer.sv
// Stimulus sequencer for the 4-to-2 decoder stage: a 3-bit up/down counter stepped by a
// debounced push-button, plus a captured auxiliary bit, all registered.
// Optional feature: define SEQ_AUTORUN_EN to add a free-running prescaler that issues an
// automatic step every AUTO_DIV cycles while auto_mode = 1.
module decoder_stim_sequencer
  import decoder_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned AUTO_DIV        = 50_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_step,
  input  logic dir,
  input  logic aux_in,
  input  logic hold,
  input  logic auto_mode,
  output logic A,
  output logic B,
  output logic C,
  output logic D,
  output logic valid
);

  logic                 btn_pulse;
  logic                 auto_step;
  logic                 step_fire;
  logic [SEQ_WIDTH-1:0] count_q, count_d;
  logic                 aux_q, aux_d;
  logic                 valid_q, valid_d;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_step),
    .step_pulse(btn_pulse)
  );

`ifdef SEQ_AUTORUN_EN
  localparam int unsigned PrescW = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;
  localparam logic [PrescW-1:0] PrescLast = PrescW'(AUTO_DIV - 1);

  logic [PrescW-1:0] presc_q, presc_d;

  // Prescaler next value: wraps at AUTO_DIV-1, held clear while auto_mode is off.
  always_comb begin
    presc_d = presc_q;
    if (!auto_mode || (presc_q == PrescLast)) begin
      presc_d = '0;
    end else begin
      presc_d = presc_q + PrescW'(1);
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign auto_step = auto_mode && (presc_q == PrescLast);
`else
  logic unused_cfg;
  assign unused_cfg = auto_mode | (AUTO_DIV == 0);
  assign auto_step  = 1'b0;
`endif

  // Coincident manual and auto requests merge into one step.
  assign step_fire = (btn_pulse | auto_step) & ~hold;

  // Next outputs: advance count and capture aux on an accepted step.
  always_comb begin
    count_d = count_q;
    aux_d   = aux_q;
    valid_d = step_fire;
    if (step_fire) begin
      count_d = seq_next(count_q, dir);
      aux_d   = aux_in;
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      aux_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      count_q <= count_d;
      aux_q   <= aux_d;
      valid_q <= valid_d;
    end
  end

  assign A     = count_q[2];
  assign B     = count_q[1];
  assign C     = count_q[0];
  assign D     = aux_q;
  assign valid = valid_q;

endmodule

// File: doc/decoder_stim_sequencer.md
DECODER_STIM_SEQUENCER -- requirements
Module: decoder_stim_sequencer

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, the number of consecutive stable samples needed to accept a button level.
REQ-002 The block SHALL have parameter AUTO_DIV, default 50_000_000, the clock cycles per automatic step (used only under SEQ_AUTORUN_EN).
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state is updated on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port btn_step, input, 1 bit: raw, asynchronous, bouncing step push-button, active-high.
REQ-006 The block SHALL have port dir, input, 1 bit: 1 = count up, 0 = count down; sampled on the step cycle.
REQ-007 The block SHALL have port aux_in, input, 1 bit: auxiliary level, captured into output D on each step.
REQ-008 The block SHALL have port hold, input, 1 bit: when 1, all steps are suppressed.
REQ-009 The block SHALL have port auto_mode, input, 1 bit: selects automatic stepping (effective only under SEQ_AUTORUN_EN).
REQ-010 The block SHALL have ports A, B, C, D, outputs, 1 bit each: registered stimulus for the downstream 4-to-2 decoder stage; A = count[2], B = count[1], C = count[0], D = captured aux.
REQ-011 The block SHALL have port valid, output, 1 bit: one-cycle pulse, high in the first cycle A..D hold new values.

Function
REQ-012 btn_step SHALL pass through a 2-flop synchronizer before any use.
REQ-013 The debouncer FSM SHALL have three states:
- IDLE: leave when the synced button = 1.
- CONFIRM: count stable-high samples; return to IDLE on any 0; go to PRESSED when the count reaches DEBOUNCE_CYCLES.
- PRESSED: return to IDLE after DEBOUNCE_CYCLES consecutive 0 samples.
REQ-014 The debouncer SHALL emit a one-cycle step pulse on the CONFIRM->PRESSED transition only, so one press gives exactly one step, however long it is held.
REQ-015 On a step with hold = 0, count SHALL become count+1 (dir = 1) or count-1 (dir = 0), modulo 8: 7 up wraps to 0, 0 down wraps to 7.
REQ-016 On the same step edge, D SHALL take aux_in.
REQ-017 Step latency SHALL be 1 cycle from the step pulse to A..D updating; valid SHALL rise in that same cycle.
REQ-018 With hold = 1, steps SHALL be discarded (not queued), A..D SHALL be unchanged, and valid SHALL stay 0.
REQ-019 A manual step and an auto step in the same cycle SHALL produce a single increment/decrement, with one valid.
REQ-020 A..D SHALL be stable between steps; the outputs SHALL have no combinational path from any input.

Reset
REQ-021 While rst_n = 0, the block SHALL hold: count = 0, D = 0, valid = 0, debouncer in IDLE with counter 0, synchronizer flops 0, prescaler 0.
REQ-022 Asserting rst_n mid-press or mid-debounce SHALL abort it; after release, a new full debounce is required before any step.
REQ-023 The first step after reset SHALL give A,B,C = 0,0,1 when dir = 1 and 1,1,1 when dir = 0.

Configuration
REQ-024 With macro SEQ_AUTORUN_EN defined, the block SHALL include a prescaler counting to AUTO_DIV-1; while auto_mode = 1 it SHALL issue one step each time it wraps, subject to hold and dir.
REQ-025 The prescaler SHALL clear when auto_mode = 0.
REQ-026 Without SEQ_AUTORUN_EN, the prescaler logic SHALL be absent, auto_mode SHALL be ignored, and only debounced button steps SHALL occur.

Structure
REQ-027 A shared package decoder_pkg SHALL hold:
- the debouncer state enum (IDLE, CONFIRM, PRESSED);
- constant SEQ_WIDTH = 3;
- constant SEQ_MAX = 7.
REQ-028 The debouncer (synchronizer + FSM + pulse) SHALL be a sub-module named button_debouncer, reusable for other board buttons.

Verification
REQ-029 The bench SHALL cover these directed scenarios (DEBOUNCE_CYCLES = 4 for simulation):
- Reset release, then a clean 10-cycle press with dir = 1, aux_in = 1 -> A,B,C,D = 0,0,1,1; exactly one valid pulse.
- Press bouncing 1-0-1-0 at 2-cycle spacing, then stable for 10 cycles -> exactly one step; no step during the bounce.
- dir = 1, 8 presses from 0 -> count returns to 0 after 1..7; then dir = 0, one press -> A,B,C = 1,1,1.
- hold = 1 during 3 presses -> no output change and no valid; after hold = 0, the next press steps once from the prior value.
- rst_n asserted during CONFIRM with count = 5 -> outputs 0 at once; the button still held at release does not step until it is released and re-pressed.
- SEQ_AUTORUN_EN defined, AUTO_DIV = 10, auto_mode = 1, dir = 1 -> valid every 10 cycles, count 0->1->2...; a manual step coinciding with an auto step advances by 1 only.
